// File: rtl/defines_package.sv
// Shared rasterizer types.
// Point2D carries signed 16-bit screen coordinates.
package defines_package;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
   } Point2D;

endpackage

// File: rtl/tri_edge_sequencer.sv
// Wireframe triangle front-end: walks the three edges through the
// line engine with x-ordered endpoints, watchdog and abort.
module tri_edge_sequencer
   import defines_package::*;
#(
   parameter int TIMEOUT_CYCLES  = 4096,
   parameter bit SKIP_DEGENERATE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tri_valid,
   output logic       tri_ready,
   input  Point2D     v0,
   input  Point2D     v1,
   input  Point2D     v2,
   input  logic       abort,
   output logic       line_start,
   output Point2D     line_p,
   output Point2D     line_q,
   input  logic       line_done,
   output logic [1:0] edge_idx,
   output logic       tri_done,
   output logic       err_timeout
);

   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_START,
      S_WAIT,
      S_NEXT,
      S_DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   Point2D        va_q;
   Point2D        vb_q;
   Point2D        vc_q;
   logic [WW-1:0] wd_q;

   Point2D pa;
   Point2D pb;
   logic   swap;
   logic   degen;

   logic accept;
   logic ld_pair;
   logic inc_edge;
   logic set_err;
   logic wd_clr;
   logic wd_inc;

   always_comb begin
      pa = va_q;
      pb = vb_q;
      unique case (1'b1)
         (edge_idx == 2'd1): begin
            pa = vb_q;
            pb = vc_q;
         end
         (edge_idx == 2'd2): begin
            pa = vc_q;
            pb = va_q;
         end
         default: ;
      endcase
   end

   // Lexicographic (x, then y) order so the engine always steps +x.
   assign swap = ($signed(pa.x) > $signed(pb.x)) ||
                 ((pa.x == pb.x) && ($signed(pa.y) > $signed(pb.y)));
   assign degen = (pa == pb);

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      ld_pair  = 1'b0;
      inc_edge = 1'b0;
      set_err  = 1'b0;
      wd_clr   = 1'b0;
      wd_inc   = 1'b0;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tri_valid) begin
                  accept  = 1'b1;
                  state_d = S_SETUP;
               end
            end
            S_SETUP: begin
               ld_pair = 1'b1;
               if (degen && SKIP_DEGENERATE)
                  state_d = S_NEXT;
               else
                  state_d = S_START;
            end
            S_START: begin
               wd_clr  = 1'b1;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (line_done) begin
                  state_d = S_NEXT;
               end else if (wd_q == WD_LAST) begin
                  set_err = 1'b1;
                  state_d = S_NEXT;
               end else begin
                  wd_inc = 1'b1;
               end
            end
            S_NEXT: begin
               if (edge_idx == 2'd2) begin
                  state_d = S_DONE;
               end else begin
                  inc_edge = 1'b1;
                  state_d  = S_SETUP;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         va_q        <= '0;
         vb_q        <= '0;
         vc_q        <= '0;
         line_p      <= '0;
         line_q      <= '0;
         edge_idx    <= 2'd0;
         err_timeout <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            va_q     <= v0;
            vb_q     <= v1;
            vc_q     <= v2;
            edge_idx <= 2'd0;
         end
         if (inc_edge)
            edge_idx <= edge_idx + 2'd1;
         if (ld_pair) begin
            line_p <= swap ? pb : pa;
            line_q <= swap ? pa : pb;
         end
         if (set_err)
            err_timeout <= 1'b1;
         if (wd_clr)
            wd_q <= '0;
         else if (wd_inc)
            wd_q <= wd_q + 1'b1;
      end
   end

   assign tri_ready  = (state_q == S_IDLE);
   assign line_start = (state_q == S_START) && !abort;
   assign tri_done   = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Self-checking bench for tri_edge_sequencer: directed table,
// hand-written abort/reset/spurious-done sequences, random triangles.
module tb_tri_edge_sequencer;
   import defines_package::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tri_valid = 1'b0;
   logic       tri_ready;
   Point2D     v0 = '0;
   Point2D     v1 = '0;
   Point2D     v2 = '0;
   logic       abort = 1'b0;
   logic       line_start;
   Point2D     line_p;
   Point2D     line_q;
   logic       line_done;
   logic [1:0] edge_idx;
   logic       tri_done;
   logic       err_timeout;

   logic eng_done  = 1'b0;
   logic spur_done = 1'b0;
   assign line_done = eng_done | spur_done;

   tri_edge_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .SKIP_DEGENERATE(1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tri_valid  (tri_valid),
      .tri_ready  (tri_ready),
      .v0         (v0),
      .v1         (v1),
      .v2         (v2),
      .abort      (abort),
      .line_start (line_start),
      .line_p     (line_p),
      .line_q     (line_q),
      .line_done  (line_done),
      .edge_idx   (edge_idx),
      .tri_done   (tri_done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int     c;
      Point2D p;
      Point2D q;
      int     e;
   } start_t;

   typedef struct {
      Point2D v[3];
      int     d[3];
      int     n;
      Point2D ep[3];
      Point2D eq[3];
   } vec_t;

   start_t starts[$];
   int     dones[$];
   start_t exp_st[$];
   int     exp_done_c;
   bit     exp_err = 1'b0;
   int     dly[3];
   int     done_at = -1;
   Point2D vt[3];
   vec_t   tbl[4];

   int vectors = 0;
   int miscompares = 0;

   // Line engine model plus output monitor, both away from the edge.
   always @(negedge clk) begin
      eng_done <= (cyc == done_at);
      if (line_start) begin
         starts.push_back('{cyc, line_p, line_q, int'(edge_idx)});
         if (dly[edge_idx] > 0)
            done_at <= cyc + dly[edge_idx];
      end
      if (tri_done)
         dones.push_back(cyc);
   end

   function automatic Point2D pt(input int x, input int y);
      Point2D r;
      r.x = 16'(x);
      r.y = 16'(y);
      return r;
   endfunction

   function automatic bit after(input Point2D a, input Point2D b);
      if ($signed(a.x) != $signed(b.x))
         return $signed(a.x) > $signed(b.x);
      return $signed(a.y) > $signed(b.y);
   endfunction

   task automatic chk(input string nm, input longint act,
                      input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Schedule from the edge rules: SETUP, START, W WAIT cycles, NEXT.
   task automatic predict(input int a);
      int     s;
      int     w;
      Point2D pa;
      Point2D pb;
      exp_st.delete();
      s = a + 1;
      for (int e = 0; e < 3; e++) begin
         pa = vt[e];
         pb = vt[(e + 1) % 3];
         if (pa == pb) begin
            s += 2;
         end else begin
            if (after(pa, pb))
               exp_st.push_back('{s + 1, pb, pa, e});
            else
               exp_st.push_back('{s + 1, pa, pb, e});
            if (dly[e] == 0 || dly[e] > TO) begin
               w = TO;
               exp_err = 1'b1;
            end else begin
               w = dly[e];
            end
            s += 3 + w;
         end
      end
      exp_done_c = s;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!tri_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", longint'(tri_ready), 1);
   endtask

   task automatic accept(output int a);
      @(negedge clk);
      wait_ready();
      starts.delete();
      dones.delete();
      v0 = vt[0];
      v1 = vt[1];
      v2 = vt[2];
      tri_valid = 1'b1;
      a = cyc;
      @(negedge clk);
      tri_valid = 1'b0;
      v0 = pt(int'($urandom), int'($urandom));
      v1 = pt(int'($urandom), int'($urandom));
      v2 = pt(int'($urandom), int'($urandom));
      chk("ready_low", longint'(tri_ready), 0);
   endtask

   task automatic run_tri();
      int a;
      accept(a);
      predict(a);
      while (cyc < exp_done_c + 3)
         @(negedge clk);
      chk("n_starts", starts.size(), exp_st.size());
      for (int i = 0; i < starts.size() && i < exp_st.size(); i++) begin
         chk("start_cyc", starts[i].c, exp_st[i].c);
         chk("line_p", longint'(starts[i].p), longint'(exp_st[i].p));
         chk("line_q", longint'(starts[i].q), longint'(exp_st[i].q));
         chk("edge_idx", starts[i].e, exp_st[i].e);
      end
      chk("n_tri_done", dones.size(), 1);
      if (dones.size() > 0)
         chk("tri_done_cyc", dones[0], exp_done_c);
      chk("err_timeout", longint'(err_timeout), longint'(exp_err));
   endtask

   task automatic chk_reset_outs();
      chk("rst_ready", longint'(tri_ready), 1);
      chk("rst_start", longint'(line_start), 0);
      chk("rst_p", longint'(line_p), 0);
      chk("rst_q", longint'(line_q), 0);
      chk("rst_edge", longint'(edge_idx), 0);
      chk("rst_done", longint'(tri_done), 0);
      chk("rst_err", longint'(err_timeout), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int a;
      int ns;
      int nd;
      dly = '{5, 5, 5};

      tbl[0].v  = '{pt(0, 0), pt(10, 4), pt(3, 9)};
      tbl[0].d  = '{5, 5, 5};
      tbl[0].n  = 3;
      tbl[0].ep = '{pt(0, 0), pt(3, 9), pt(0, 0)};
      tbl[0].eq = '{pt(10, 4), pt(10, 4), pt(3, 9)};
      tbl[1].v  = '{pt(5, 8), pt(5, 2), pt(1, 2)};
      tbl[1].d  = '{3, 7, 1};
      tbl[1].n  = 3;
      tbl[1].ep = '{pt(5, 2), pt(1, 2), pt(1, 2)};
      tbl[1].eq = '{pt(5, 8), pt(5, 2), pt(5, 8)};
      tbl[2].v  = '{pt(7, 7), pt(7, 7), pt(9, 1)};
      tbl[2].d  = '{5, 5, 16};
      tbl[2].n  = 2;
      tbl[2].ep = '{pt(7, 7), pt(7, 7), pt(0, 0)};
      tbl[2].eq = '{pt(9, 1), pt(9, 1), pt(0, 0)};
      tbl[3].v  = '{pt(-3, 5), pt(2, -7), pt(0, 0)};
      tbl[3].d  = '{0, 0, 0};
      tbl[3].n  = 3;
      tbl[3].ep = '{pt(-3, 5), pt(0, 0), pt(-3, 5)};
      tbl[3].eq = '{pt(2, -7), pt(2, -7), pt(0, 0)};

      repeat (3) @(negedge clk);
      chk_reset_outs();
      rst = 1'b0;

      for (int r = 0; r < 4; r++) begin
         vt  = tbl[r].v;
         dly = tbl[r].d;
         run_tri();
         chk("tbl_n", starts.size(), tbl[r].n);
         for (int i = 0; i < tbl[r].n && i < starts.size(); i++) begin
            chk("tbl_p", longint'(starts[i].p), longint'(tbl[r].ep[i]));
            chk("tbl_q", longint'(starts[i].q), longint'(tbl[r].eq[i]));
         end
      end
      chk("err_after_to", longint'(err_timeout), 1);

      ns = starts.size();
      nd = dones.size();
      repeat (4) begin
         @(negedge clk);
         spur_done = 1'b1;
      end
      @(negedge clk);
      spur_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_ready", longint'(tri_ready), 1);
      chk("spur_starts", starts.size(), ns);
      chk("spur_dones", dones.size(), nd);

      vt  = '{pt(1, 1), pt(8, 3), pt(4, 6)};
      dly = '{5, 5, 5};
      accept(a);
      while (cyc < a + 12)
         @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", longint'(tri_ready), 1);
      chk("abort_start", longint'(line_start), 0);
      repeat (12) @(negedge clk);
      chk("abort_starts", starts.size(), 2);
      chk("abort_no_done", dones.size(), 0);
      if (starts.size() > 1)
         chk("abort_edge", starts[1].e, 1);

      vt  = '{pt(6, -2), pt(-4, 3), pt(6, 9)};
      dly = '{4, 2, 6};
      run_tri();

      vt  = '{pt(2, 2), pt(9, 9), pt(0, 5)};
      dly = '{0, 0, 0};
      accept(a);
      while (cyc < a + 5)
         @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outs();
      rst = 1'b0;
      exp_err = 1'b0;

      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < 3; j++) begin
            if ($urandom_range(0, 3) == 0)
               vt[j] = pt(int'($urandom), int'($urandom));
            else
               vt[j] = pt(int'($urandom_range(0, 4)) - 2,
                          int'($urandom_range(0, 4)) - 2);
            dly[j] = int'($urandom_range(0, 18));
         end
         run_tri();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
